// File: rtl/clk_pkg.sv
// Shared definitions for the set-time controller and the counter bank address decoders.
package clk_pkg;

    typedef enum logic [2:0] {
        ST_RUN        = 3'd0,
        ST_EDIT_MIN   = 3'd1,
        ST_COMMIT_MIN = 3'd2,
        ST_EDIT_SEC   = 3'd3,
        ST_COMMIT_SEC = 3'd4
    } state_t;

    localparam logic [1:0] ADDR_SEC  = 2'b00;
    localparam logic [1:0] ADDR_MIN  = 2'b01;
    localparam logic [1:0] ADDR_NONE = 2'b11;

    localparam int unsigned MAX_VAL_DEF = 59;

    function automatic logic is_edit(input state_t s);
        return (s == ST_EDIT_MIN) || (s == ST_EDIT_SEC);
    endfunction

endpackage

// File: rtl/mod_updown.sv
// Wrap-around +1/-1 on a 6-bit field value; out-of-range inputs recover to 0.
module mod_updown
    import clk_pkg::*;
#(
    parameter int unsigned MAX_VAL = MAX_VAL_DEF
) (
    input  logic [5:0] val_in,
    output logic [5:0] val_inc,
    output logic [5:0] val_dec
);

    localparam logic [5:0] MAX_V = 6'(MAX_VAL);

    always_comb begin
        val_inc = (val_in >= MAX_V) ? 6'd0 : val_in + 6'd1;
        if (val_in == 6'd0) begin
            val_dec = MAX_V;
        end else if (val_in > MAX_V) begin
            val_dec = 6'd0;
        end else begin
            val_dec = val_in - 6'd1;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Set-time controller: edits minutes then seconds and writes each into the counter bank.
//   state         | meaning
//   ST_RUN        | clock running, buttons other than mode ignored
//   ST_EDIT_MIN   | editing minutes, blink active
//   ST_COMMIT_MIN | one-cycle write of minutes
//   ST_EDIT_SEC   | editing seconds, blink active
//   ST_COMMIT_SEC | one-cycle write of seconds
module clock_set_ctrl
    import clk_pkg::*;
#(
    parameter int unsigned MAX_VAL       = MAX_VAL_DEF,
    parameter int unsigned TIMEOUT_TICKS = 30,
    parameter int unsigned TO_W          = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tc_time_base,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [5:0] seconds_in,
    input  logic [5:0] minutes_in,
    output logic       load,
    output logic [1:0] addrs,
    output logic [5:0] data_out,
    output logic       set_active,
    output logic       blink,
    output logic [5:0] edit_value
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);

    state_t          state_q, state_d;
    logic [5:0]      edit_q, edit_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            blink_q, blink_d;
    logic            load_q, load_d;
    logic [1:0]      addrs_q, addrs_d;
    logic [5:0]      data_q, data_d;
    logic            set_active_q, set_active_d;
    logic [5:0]      val_inc, val_dec;

    mod_updown #(.MAX_VAL(MAX_VAL)) u_updown (
        .val_in  (edit_q),
        .val_inc (val_inc),
        .val_dec (val_dec)
    );

    always_comb begin
        state_d = state_q;
        edit_d  = edit_q;
        cnt_d   = '0;
        case (state_q)
            ST_RUN: begin
                if (btn_mode) begin
                    state_d = ST_EDIT_MIN;
                    edit_d  = minutes_in;
                end
            end
            ST_EDIT_MIN, ST_EDIT_SEC: begin
                // Any button restarts the timeout, even on the final tick.
                if (btn_mode) begin
                    state_d = (state_q == ST_EDIT_MIN) ? ST_COMMIT_MIN : ST_COMMIT_SEC;
                end else if (btn_up && !btn_down) begin
                    edit_d = val_inc;
                end else if (btn_down && !btn_up) begin
                    edit_d = val_dec;
                end else if (btn_up || btn_down) begin
                    edit_d = edit_q;
                end else if (tc_time_base) begin
                    if (cnt_q >= TO_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q + TO_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_COMMIT_MIN: begin
                state_d = ST_EDIT_SEC;
                edit_d  = seconds_in;
            end
            ST_COMMIT_SEC: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        load_d       = 1'b0;
        addrs_d      = ADDR_NONE;
        data_d       = 6'd0;
        set_active_d = is_edit(state_d);
        blink_d      = 1'b0;
        if (state_d == ST_COMMIT_MIN) begin
            load_d  = 1'b1;
            addrs_d = ADDR_MIN;
            data_d  = edit_q;
        end else if (state_d == ST_COMMIT_SEC) begin
            load_d  = 1'b1;
            addrs_d = ADDR_SEC;
            data_d  = edit_q;
        end
        if (is_edit(state_d)) begin
            if (!is_edit(state_q)) begin
                blink_d = 1'b1;
            end else if (tc_time_base) begin
                blink_d = ~blink_q;
            end else begin
                blink_d = blink_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            edit_q       <= 6'd0;
            cnt_q        <= '0;
            blink_q      <= 1'b0;
            load_q       <= 1'b0;
            addrs_q      <= ADDR_NONE;
            data_q       <= 6'd0;
            set_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            edit_q       <= edit_d;
            cnt_q        <= cnt_d;
            blink_q      <= blink_d;
            load_q       <= load_d;
            addrs_q      <= addrs_d;
            data_q       <= data_d;
            set_active_q <= set_active_d;
        end
    end

    assign load       = load_q;
    assign addrs      = addrs_q;
    assign data_out   = data_q;
    assign set_active = set_active_q;
    assign blink      = blink_q;
    assign edit_value = edit_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: set sequence, wrap, timeout, mode/up race, reset in commit.
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tc_time_base = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [5:0] seconds_in = 6'd0;
    logic [5:0] minutes_in = 6'd0;
    logic       load;
    logic [1:0] addrs;
    logic [5:0] data_out;
    logic       set_active;
    logic       blink;
    logic [5:0] edit_value;

    int checks = 0;
    int failures = 0;

    clock_set_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .tc_time_base (tc_time_base),
        .btn_mode     (btn_mode),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .seconds_in   (seconds_in),
        .minutes_in   (minutes_in),
        .load         (load),
        .addrs        (addrs),
        .data_out     (data_out),
        .set_active   (set_active),
        .blink        (blink),
        .edit_value   (edit_value)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs from a falling edge; returns at the next falling edge.
    task automatic step(input logic m, input logic u, input logic d, input logic t);
        @(negedge clk);
        btn_mode     = m;
        btn_up       = u;
        btn_down     = d;
        tc_time_base = t;
        @(negedge clk);
        btn_mode     = 1'b0;
        btn_up       = 1'b0;
        btn_down     = 1'b0;
        tc_time_base = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_load"}, 32'(load), 32'd0);
        check({tag, "_addrs"}, 32'(addrs), 32'd3);
        check({tag, "_data"}, 32'(data_out), 32'd0);
    endtask

    initial begin
        // Reset and idle
        #17 reset = 1'b1;
        repeat (10) @(negedge clk);
        check_idle("rst");
        check("rst_set_active", 32'(set_active), 32'd0);
        check("rst_blink", 32'(blink), 32'd0);
        check("rst_edit", 32'(edit_value), 32'd0);

        // Up/down ignored in RUN
        step(0, 1, 0, 0);
        check("run_up_ignored", 32'(edit_value), 32'd0);
        check("run_set_active", 32'(set_active), 32'd0);

        // Full set sequence: minutes 12 -> 15, seconds 40 -> 38
        minutes_in = 6'd12;
        seconds_in = 6'd40;
        step(1, 0, 0, 0);
        check("enter_edit", 32'(edit_value), 32'd12);
        check("enter_set_active", 32'(set_active), 32'd1);
        check("enter_blink", 32'(blink), 32'd1);
        check_idle("edit_min");
        repeat (3) step(0, 1, 0, 0);
        check("min_up3", 32'(edit_value), 32'd15);
        step(1, 0, 0, 0);
        check("cmin_load", 32'(load), 32'd1);
        check("cmin_addrs", 32'(addrs), 32'd1);
        check("cmin_data", 32'(data_out), 32'd15);
        check("cmin_set_active", 32'(set_active), 32'd0);
        check("cmin_blink", 32'(blink), 32'd0);
        @(negedge clk);
        check_idle("edit_sec");
        check("sec_capture", 32'(edit_value), 32'd40);
        check("sec_set_active", 32'(set_active), 32'd1);
        check("sec_blink", 32'(blink), 32'd1);
        repeat (2) step(0, 0, 1, 0);
        check("sec_down2", 32'(edit_value), 32'd38);
        step(1, 0, 0, 0);
        check("csec_load", 32'(load), 32'd1);
        check("csec_addrs", 32'(addrs), 32'd0);
        check("csec_data", 32'(data_out), 32'd38);
        @(negedge clk);
        check_idle("back_run");
        check("back_run_set_active", 32'(set_active), 32'd0);

        // Wrap checks
        minutes_in = 6'd59;
        step(1, 0, 0, 0);
        check("wrap_capture", 32'(edit_value), 32'd59);
        step(0, 1, 0, 0);
        check("wrap_up", 32'(edit_value), 32'd0);
        step(0, 0, 1, 0);
        check("wrap_down", 32'(edit_value), 32'd59);
        step(0, 1, 1, 0);
        check("up_down_same", 32'(edit_value), 32'd59);
        step(1, 0, 0, 0);
        check("wrap_commit", 32'(data_out), 32'd59);
        @(negedge clk);
        step(1, 0, 0, 0);
        @(negedge clk);
        check("wrap_exit", 32'(set_active), 32'd0);

        // Corrupt captured value recovers to 0
        minutes_in = 6'd62;
        step(1, 0, 0, 0);
        check("corrupt_capture", 32'(edit_value), 32'd62);
        step(0, 0, 1, 0);
        check("corrupt_down", 32'(edit_value), 32'd0);
        step(1, 0, 0, 0);
        @(negedge clk);
        step(1, 0, 0, 0);
        @(negedge clk);

        // Timeout after 30 ticks, blink toggling each tick
        minutes_in = 6'd5;
        step(1, 0, 0, 0);
        check("to_enter_blink", 32'(blink), 32'd1);
        for (int i = 1; i < 30; i++) begin
            step(0, 0, 0, 1);
            check("to_blink", 32'(blink), 32'(i % 2 == 0));
            check("to_active", 32'(set_active), 32'd1);
            check("to_load", 32'(load), 32'd0);
        end
        step(0, 0, 0, 1);
        check("to_exit_active", 32'(set_active), 32'd0);
        check("to_exit_blink", 32'(blink), 32'd0);
        check_idle("to_exit");
        repeat (3) @(negedge clk);
        check("to_later_load", 32'(load), 32'd0);

        // Button on final tick wins: counter restarts
        step(1, 0, 0, 0);
        for (int i = 0; i < 29; i++) step(0, 0, 0, 1);
        step(0, 1, 0, 1);
        check("lasttick_btn_active", 32'(set_active), 32'd1);
        check("lasttick_btn_val", 32'(edit_value), 32'd6);
        step(0, 0, 0, 1);
        check("lasttick_restart", 32'(set_active), 32'd1);
        step(1, 0, 0, 0);
        @(negedge clk);
        step(1, 0, 0, 0);
        @(negedge clk);

        // Mode and up in the same cycle: commit pre-up value
        minutes_in = 6'd20;
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        check("race_load", 32'(load), 32'd1);
        check("race_addrs", 32'(addrs), 32'd1);
        check("race_data", 32'(data_out), 32'd20);
        @(negedge clk);
        step(1, 0, 0, 0);
        @(negedge clk);
        check("race_exit", 32'(set_active), 32'd0);

        // Reset asserted during COMMIT_MIN
        minutes_in = 6'd7;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("rc_load_before", 32'(load), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("rc_load_async", 32'(load), 32'd0);
        check("rc_addrs_async", 32'(addrs), 32'd3);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("rc_after");
        check("rc_after_active", 32'(set_active), 32'd0);
        check("rc_after_edit", 32'(edit_value), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Time-set controller for the seconds/minutes real-clock datapath. It turns three single-cycle user pulses (mode, up, down) into a set-time sequence: minutes are edited first, then seconds. Each committed value is written into the counters through their shared load/addrs/data_in port. It sits between the debounced button logic and the counter bank, and drives that bank's load, addrs and data_in inputs.

Parameters:
MAX_VAL, 59, highest legal field value; up/down wrap between MAX_VAL and 0
TIMEOUT_TICKS, 30, time-base ticks with no button activity before an edit is aborted
TO_W, 5, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_TICKS

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  asynchronous, active-low reset
tc_time_base  in  1  one-cycle pulse per second from the time base
btn_mode  in  1  one-cycle pulse: enter edit / advance field / commit
btn_up  in  1  one-cycle pulse: increment the edited value
btn_down  in  1  one-cycle pulse: decrement the edited value
seconds_in  in  6  live seconds count from the counter bank
minutes_in  in  6  live minutes count from the counter bank
load  out  1  one-cycle write strobe to the counter bank
addrs  out  2  write target: 2'b00 = seconds, 2'b01 = minutes; 2'b11 when idle
data_out  out  6  value to write; connects to the counter bank's data_in
set_active  out  1  high while in EDIT_MIN or EDIT_SEC
blink  out  1  display blink phase for the edited field
edit_value  out  6  current edit register, for the display

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = RUN; load = 0; addrs = 2'b11; data_out = 0.
  - edit_value = 0; set_active = 0; blink = 0; timeout counter = 0.
- All outputs are registered.
- States: RUN, EDIT_MIN, COMMIT_MIN, EDIT_SEC, COMMIT_SEC.
- RUN:
  - btn_mode -> EDIT_MIN next cycle; edit_value <= minutes_in as sampled that same cycle.
  - btn_up and btn_down are ignored.
- EDIT_MIN and EDIT_SEC:
  - btn_up: edit_value <= (edit_value == MAX_VAL) ? 0 : edit_value + 1.
  - btn_down: edit_value <= (edit_value == 0) ? MAX_VAL : edit_value - 1.
  - btn_up and btn_down in the same cycle: no change.
  - btn_mode in the same cycle as up/down: mode wins; the up/down pulse is discarded.
  - edit_value above MAX_VAL on capture (corrupt counter): the first up or down loads 0.
  - In EDIT_MIN, btn_mode -> COMMIT_MIN. In EDIT_SEC, btn_mode -> COMMIT_SEC.
- COMMIT_MIN (exactly one cycle):
  - load = 1, addrs = 2'b01, data_out = edit_value.
  - Then -> EDIT_SEC, with edit_value <= seconds_in as sampled in COMMIT_MIN.
- COMMIT_SEC (exactly one cycle):
  - load = 1, addrs = 2'b00, data_out = edit_value.
  - Then -> RUN.
- Latency: load rises on the first clock edge after the btn_mode pulse is sampled, and is high for exactly one cycle.
- load is 0 in every state except COMMIT_MIN and COMMIT_SEC.
- addrs = 2'b11 and data_out = 0 whenever load = 0.
- Timeout:
  - The counter clears on entering an edit state and on any btn_up/btn_down/btn_mode pulse.
  - It increments on tc_time_base while in an edit state.
  - When it reaches TIMEOUT_TICKS -> RUN with no load; a minutes value already committed stays committed.
  - A button pulse in the same cycle as the final tick: the button wins and the counter clears.
- blink:
  - Toggles on each tc_time_base while in an edit state.
  - Forced to 1 on entering an edit state.
  - Forced to 0 in RUN and in the COMMIT states.
- set_active = 1 in EDIT_MIN and EDIT_SEC, and 0 in all other states.
- Reset during a COMMIT state:
  - load drops asynchronously.
  - No partial write is required to persist.

Decomposition:
- Shared package clk_pkg holds:
  - the state enum;
  - address constants ADDR_SEC = 2'b00, ADDR_MIN = 2'b01, ADDR_NONE = 2'b11;
  - the default MAX_VAL.
- The counter bank's decoders use the same address constants.
- One natural sub-module, mod_updown: combinational wrap-around +1/-1 on a 6-bit value with a parameterised MAX_VAL.
- FSM, timeout counter and output registers stay in the top module.

Test Plan:
- Reset release, idle 10 cycles -> load = 0, addrs = 2'b11, set_active = 0, blink = 0.
- minutes_in = 12, seconds_in = 40; mode, up×3, mode, down×2, mode:
  - one load with addrs = 01, data_out = 15;
  - one load with addrs = 00, data_out = 38;
  - state returns to RUN.
- Wrap checks:
  - edit_value = 59, up -> 0;
  - edit_value = 0, down -> 59;
  - up and down in the same cycle -> value unchanged.
- Enter EDIT_MIN, then 30 tc_time_base pulses with no buttons:
  - return to RUN with no load issued;
  - blink toggled on every tick.
- Mode and up in the same cycle during EDIT_MIN -> commit of the pre-up value; the up is discarded.
- Assert reset in the COMMIT_MIN cycle:
  - load deasserts immediately (asynchronously);
  - state is RUN after release.
